// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot sequencer: FSM states,
// frame sync byte, default load address and frame-length width.
package boot_pkg;

  localparam logic [7:0]  SYNC_BYTE         = 8'hA5;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_8000;
  localparam int unsigned LEN_W             = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } boot_state_e;

  // Byte address of word idx relative to base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [LEN_W-1:0] idx);
    return base + {{(32-LEN_W-2){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs payload bytes into little-endian 32-bit words, keeps the running
// XOR checksum and issues a registered instruction-memory write per word.
module boot_word_assembler
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             byte_en,
  input  logic [7:0]       byte_data,
  output logic             last_byte,
  output logic [LEN_W-1:0] word_idx,
  output logic [7:0]       chk,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata
);

  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      shift_q,    shift_d;
  logic [7:0]       chk_q,      chk_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic             we_q,       we_d;
  logic [31:0]      addr_q,     addr_d;
  logic [31:0]      wdata_q,    wdata_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    chk_d      = chk_q;
    word_idx_d = word_idx_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (clear) begin
      byte_idx_d = '0;
      shift_d    = '0;
      chk_d      = '0;
      word_idx_d = '0;
    end else if (byte_en) begin
      chk_d      = chk_q ^ byte_data;
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0: shift_d[7:0]   = byte_data;
        2'd1: shift_d[15:8]  = byte_data;
        2'd2: shift_d[23:16] = byte_data;
        default: begin
          // Address/data are latched with the strobe so they stay valid
          // while the next word already starts assembling.
          we_d       = 1'b1;
          addr_d     = word_addr(BASE_ADDR, word_idx_q);
          wdata_d    = {byte_data, shift_q};
          word_idx_d = word_idx_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q <= '0;
      shift_q    <= '0;
      chk_q      <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      chk_q      <= chk_d;
      word_idx_q <= word_idx_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign last_byte  = (byte_idx_q == 2'd3);
  assign word_idx   = word_idx_q;
  assign chk        = chk_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/uart_boot_sequencer.sv
// Boot sequencer: holds the core, loads a framed UART image into
// instruction memory, verifies its XOR checksum and releases the PC.
module uart_boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 64,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        pc_load,
  output logic [31:0] pc_load_val,
  output logic        boot_done,
  output logic        boot_error
);

  boot_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [LEN_W-1:0] len_full;
  logic             rx_fire;
  logic             asm_clear;
  logic             asm_byte_en;
  logic             asm_last_byte;
  logic [LEN_W-1:0] asm_word_idx;
  logic [7:0]       asm_chk;

  // Ready depends on state only, keeping it free of any path from rx_valid.
  assign rx_ready = !(state_q == S_RELEASE || state_q == S_RUN);
  assign rx_fire  = rx_valid && rx_ready;
  assign len_full = {rx_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cpu_hold    = 1'b1;
    pc_load     = 1'b0;
    boot_done   = 1'b0;
    boot_error  = 1'b0;
    asm_clear   = 1'b0;
    asm_byte_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_fire && rx_data == SYNC_BYTE) begin
          state_d   = S_LEN0;
          asm_clear = 1'b1;
        end
      end
      S_LEN0: begin
        if (rx_fire) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (rx_fire) begin
          len_d = len_full;
          if (len_full != '0 && 32'(len_full) <= NUM_WORDS) state_d = S_DATA;
          else                                               state_d = S_ERROR;
        end
      end
      S_DATA: begin
        if (rx_fire) begin
          asm_byte_en = 1'b1;
          if (asm_last_byte && (asm_word_idx + 1'b1) == len_q) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rx_fire) state_d = (rx_data == asm_chk) ? S_RELEASE : S_ERROR;
      end
      S_RELEASE: begin
        pc_load = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        cpu_hold  = 1'b0;
        boot_done = 1'b1;
        if (boot_req) state_d = S_IDLE;
      end
      S_ERROR: begin
        boot_error = 1'b1;
        // A fresh sync wins over boot_req so the incoming frame is not lost.
        if (rx_fire && rx_data == SYNC_BYTE) begin
          state_d   = S_LEN0;
          asm_clear = 1'b1;
        end else if (boot_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  boot_word_assembler #(
    .BASE_ADDR (BASE_ADDR)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_en    (asm_byte_en),
    .byte_data  (rx_data),
    .last_byte  (asm_last_byte),
    .word_idx   (asm_word_idx),
    .chk        (asm_chk),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata)
  );

  assign pc_load_val = BASE_ADDR;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Self-checking bench for uart_boot_sequencer: directed and random frames
// compared against a frame-level model of the expected writes and outcome.
module tb_uart_boot_sequencer;

  localparam int unsigned NW   = 64;
  localparam logic [31:0] BASE = 32'h0000_8000;

  logic        clk;
  logic        rst;
  logic        boot_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        boot_done;
  logic        boot_error;

  uart_boot_sequencer #(
    .NUM_WORDS (NW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .boot_req    (boot_req),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_hold    (cpu_hold),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .boot_done   (boot_done),
    .boot_error  (boot_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] wr_q[$];
  int unsigned pc_cnt = 0;

  // Write/PC-load observer, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_wdata});
    if (pc_load === 1'b1) pc_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_ready", 64'(rx_ready), 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic to_idle();
    if (boot_done === 1'b1 || boot_error === 1'b1) begin
      boot_req = 1'b1;
      @(negedge clk);
      boot_req = 1'b0;
    end
  endtask

  // Frame-level model: valid length yields len word writes at BASE+4i with
  // little-endian data; success additionally needs a matching XOR checksum.
  task automatic run_frame(input logic [7:0] pay[$], input logic [15:0] len,
                           input logic [7:0] mask, input logic [7:0] garb[$],
                           input bit gaps);
    logic [7:0]  chk;
    logic [31:0] w;
    bit          len_ok;
    bit          good;
    chk    = 8'h00;
    len_ok = (len >= 1) && (len <= NW);
    good   = len_ok && (mask == 8'h00);
    foreach (pay[i]) chk = chk ^ pay[i];
    to_idle();
    wr_q.delete();
    pc_cnt = 0;
    foreach (garb[i]) send_byte(garb[i]);
    send_byte(8'hA5);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    if (!len_ok) begin
      check_eq("len_err", 64'(boot_error), 64'd1);
      check_eq("len_hold", 64'(cpu_hold), 64'd1);
      repeat (3) @(negedge clk);
      check_eq("len_nwr", 64'(wr_q.size()), 64'd0);
      check_eq("len_err2", 64'(boot_error), 64'd1);
      return;
    end
    foreach (pay[i]) begin
      send_byte(pay[i]);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send_byte(chk ^ mask);
    if (good) begin
      check_eq("rel_pcload", 64'(pc_load), 64'd1);
      check_eq("rel_pcval", 64'(pc_load_val), 64'(BASE));
      check_eq("rel_hold", 64'(cpu_hold), 64'd1);
      check_eq("rel_done", 64'(boot_done), 64'd0);
      @(negedge clk);
      check_eq("run_pcload", 64'(pc_load), 64'd0);
      check_eq("run_hold", 64'(cpu_hold), 64'd0);
      check_eq("run_done", 64'(boot_done), 64'd1);
      check_eq("run_ready", 64'(rx_ready), 64'd0);
    end else begin
      check_eq("chk_err", 64'(boot_error), 64'd1);
      check_eq("chk_hold", 64'(cpu_hold), 64'd1);
      check_eq("chk_pcload", 64'(pc_load), 64'd0);
      @(negedge clk);
      check_eq("chk_err2", 64'(boot_error), 64'd1);
      check_eq("chk_done", 64'(boot_done), 64'd0);
    end
    check_eq("pc_cnt", 64'(pc_cnt), good ? 64'd1 : 64'd0);
    check_eq("n_writes", 64'(wr_q.size()), 64'(len));
    for (int unsigned i = 0; i < len && i < wr_q.size(); i++) begin
      w = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
      check_eq("write", wr_q[i], {BASE + 32'(4*i), w});
    end
  endtask

  initial begin
    logic [7:0]  pay[$];
    logic [7:0]  garb[$];
    logic [15:0] len;
    logic [7:0]  mask;
    logic [7:0]  b;
    rst      = 1'b0;
    boot_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    repeat (2) @(negedge clk);
    check_eq("rst_hold", 64'(cpu_hold), 64'd1);
    check_eq("rst_we", 64'(imem_we), 64'd0);
    check_eq("rst_pcload", 64'(pc_load), 64'd0);
    check_eq("rst_done", 64'(boot_done), 64'd0);
    check_eq("rst_err", 64'(boot_error), 64'd0);
    check_eq("rst_addr", 64'(imem_addr), 64'(BASE));
    check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
    check_eq("rst_ready", 64'(rx_ready), 64'd1);
    rst = 1'b1;
    @(negedge clk);

    pay  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h80, 8'h00};
    garb = {};
    run_frame(pay, 16'd2, 8'h00, garb, 1'b0);
    if (wr_q.size() >= 2) begin
      check_eq("dir_w0", wr_q[0], {32'h0000_8000, 32'h0000_0013});
      check_eq("dir_w1", wr_q[1], {32'h0000_8004, 32'h0080_006F});
    end

    rx_valid = 1'b1;
    rx_data  = 8'h11;
    repeat (3) begin
      @(negedge clk);
      check_eq("run_bp_ready", 64'(rx_ready), 64'd0);
      check_eq("run_bp_done", 64'(boot_done), 64'd1);
    end
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    check_eq("breq_hold", 64'(cpu_hold), 64'd1);
    check_eq("breq_ready", 64'(rx_ready), 64'd1);
    check_eq("breq_done", 64'(boot_done), 64'd0);
    rx_valid = 1'b0;

    run_frame(pay, 16'd2, 8'hFC, garb, 1'b0);
    run_frame(pay, 16'd2, 8'h00, garb, 1'b0);

    pay = {};
    run_frame(pay, 16'd0, 8'h00, garb, 1'b0);
    run_frame(pay, 16'(NW + 1), 8'h00, garb, 1'b0);

    pay  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h80, 8'h00};
    garb = '{8'h00, 8'hFF, 8'h12};
    run_frame(pay, 16'd2, 8'h00, garb, 1'b0);

    pay  = {};
    garb = {};
    for (int unsigned i = 0; i < 4 * NW; i++) pay.push_back(8'($urandom));
    run_frame(pay, 16'(NW), 8'h00, garb, 1'b0);

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 9))
        0:       len = 16'd0;
        1:       len = 16'(NW + 1 + $urandom_range(0, 1000));
        default: len = 16'($urandom_range(1, 6));
      endcase
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      pay  = {};
      garb = {};
      if (len >= 1 && len <= NW)
        for (int unsigned i = 0; i < 4 * len; i++) pay.push_back(8'($urandom));
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        garb.push_back((b == 8'hA5) ? 8'h5A : b);
      end
      run_frame(pay, len, mask, garb, 1'($urandom_range(0, 1)));
    end

    to_idle();
    wr_q.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
    #1 rst = 1'b0;
    #1;
    check_eq("mid_nwr", 64'(wr_q.size()), 64'd1);
    check_eq("mid_hold", 64'(cpu_hold), 64'd1);
    check_eq("mid_we", 64'(imem_we), 64'd0);
    check_eq("mid_pcload", 64'(pc_load), 64'd0);
    check_eq("mid_done", 64'(boot_done), 64'd0);
    check_eq("mid_err", 64'(boot_error), 64'd0);
    check_eq("mid_addr", 64'(imem_addr), 64'(BASE));
    check_eq("mid_wdata", 64'(imem_wdata), 64'd0);
    check_eq("mid_ready", 64'(rx_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("post_rst_nwr", 64'(wr_q.size()), 64'd1);
    check_eq("post_rst_hold", 64'(cpu_hold), 64'd1);

    pay = {};
    for (int unsigned i = 0; i < 12; i++) pay.push_back(8'($urandom));
    run_frame(pay, 16'd3, 8'h00, garb, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
